// File: rtl/a2d_scan_intf.sv
// Multi-channel SPI scanner for the line follower's A2D: one 32-bit frame per masked channel.
// Optional A2D_RES_INV_EN stores the inverted result (IR sensors read high-is-dark).
module a2d_scan_intf #(
    parameter int NUM_CHNNL     = 8,
    parameter int SCLK_DIV_LOG2 = 5,
    parameter int RES_W         = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 strt_scan,
    input  logic [NUM_CHNNL-1:0] chnnl_mask,
    output logic                 busy,
    output logic                 scan_done,
    input  logic [2:0]           rd_chnnl,
    output logic [RES_W-1:0]     rd_res,
    output logic [NUM_CHNNL-1:0] res_vld,
    output logic                 a2d_SS_n,
    output logic                 SCLK,
    output logic                 MOSI,
    input  logic                 MISO
);
    // state | meaning
    // IDLE  | waiting for strt_scan; SS_n/SCLK high
    // FRAME | SS_n low, 32-bit SPI transfer for channel ch_q
    // GAP   | SS_n high for half an SCLK period before next frame or scan end
    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    localparam int D = SCLK_DIV_LOG2;
    localparam logic [D-1:0] CNT_HALF = {1'b1, {(D-1){1'b0}}};
    localparam logic [D-1:0] CNT_PRE  = {1'b0, {(D-1){1'b1}}};
    localparam logic [D-1:0] CNT_ONES = {D{1'b1}};
    localparam logic [D-2:0] GAP_LOAD = {(D-1){1'b1}};

    state_t                 state_q, state_d;
    logic [D-1:0]           cnt_q, cnt_d;
    logic [D-2:0]           gap_q, gap_d;
    logic [5:0]             rise_q, rise_d;
    logic [31:0]            tx_q, tx_d;
    logic [31:0]            rx_q, rx_d;
    logic [2:0]             ch_q, ch_d;
    logic [NUM_CHNNL-1:0]   pend_q, pend_d;
    logic [NUM_CHNNL-1:0]   vld_q, vld_d;
    logic [RES_W-1:0]       res_q [NUM_CHNNL];
    logic [RES_W-1:0]       res_d [NUM_CHNNL];
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   ss_n_q, ss_n_d;
    logic                   sclk_q, sclk_d;
    logic                   load_frame;
    logic [NUM_CHNNL-1:0]   load_mask;
    logic [RES_W-1:0]       res_new;

    function automatic logic [2:0] first_ch(input logic [NUM_CHNNL-1:0] m);
        first_ch = '0;
        for (int i = NUM_CHNNL - 1; i >= 0; i--)
            if (m[i]) first_ch = 3'(i);
    endfunction

`ifdef A2D_RES_INV_EN
    assign res_new = ~rx_q[RES_W-1:0];
`else
    assign res_new = rx_q[RES_W-1:0];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        rise_d     = rise_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        ch_d       = ch_q;
        pend_d     = pend_q;
        vld_d      = vld_q;
        res_d      = res_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ss_n_d     = ss_n_q;
        sclk_d     = sclk_q;
        load_frame = 1'b0;
        load_mask  = '0;
        case (state_q)
            IDLE: begin
                if (strt_scan) begin
                    if (|chnnl_mask) begin
                        load_frame = 1'b1;
                        load_mask  = chnnl_mask;
                        vld_d      = vld_q & ~chnnl_mask;
                        busy_d     = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FRAME: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_ONES && rise_q == 6'd32) begin
                    state_d      = GAP;
                    gap_d        = GAP_LOAD;
                    ss_n_d       = 1'b1;
                    sclk_d       = 1'b1;
                    tx_d         = '0;
                    res_d[ch_q]  = res_new;
                    vld_d[ch_q]  = 1'b1;
                end else begin
                    sclk_d = cnt_d[D-1];
                    // no rise yet means this is the first fall: bit 31 is already on MOSI
                    if (cnt_q == CNT_ONES && rise_q != 6'd0)
                        tx_d = {tx_q[30:0], 1'b0};
                    if (cnt_q == CNT_PRE) begin
                        rx_d   = {rx_q[30:0], MISO};
                        rise_d = rise_q + 6'd1;
                    end
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    if (|pend_q) begin
                        load_frame = 1'b1;
                        load_mask  = pend_q;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load_frame) begin
            state_d      = FRAME;
            ch_d         = first_ch(load_mask);
            pend_d       = load_mask;
            pend_d[ch_d] = 1'b0;
            ss_n_d       = 1'b0;
            sclk_d       = 1'b1;
            cnt_d        = CNT_HALF;
            rise_d       = '0;
            rx_d         = '0;
            tx_d         = {2'b00, ch_d, 27'h0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            rise_q  <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            ch_q    <= '0;
            pend_q  <= '0;
            vld_q   <= '0;
            res_q   <= '{default: '0};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            sclk_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            rise_q  <= rise_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            ch_q    <= ch_d;
            pend_q  <= pend_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ss_n_q  <= ss_n_d;
            sclk_q  <= sclk_d;
        end
    end

    assign busy      = busy_q;
    assign scan_done = done_q;
    assign res_vld   = vld_q;
    assign a2d_SS_n  = ss_n_q;
    assign SCLK      = sclk_q;
    assign MOSI      = tx_q[31];
    assign rd_res    = (32'(rd_chnnl) < NUM_CHNNL) ? res_q[rd_chnnl] : '0;

endmodule

// File: doc/a2d_scan_intf.md
# a2d_scan_intf

Parametrised multi-channel SPI front end for the line follower's A2D converter. It scans any subset of up to 8 A2D channels in one command, one SPI transaction per channel, with no per-channel handshake from the controller. Results are kept in a per-channel register file with valid flags, so the controller reads IR sensor values at any time. It sits between the line-follow controller and the off-chip A2D, replacing single-channel conversions.

## Interface
- NUM_CHNNL, 8: channels scanned, 1..8; channel index i maps to A2D channel code i.
- SCLK_DIV_LOG2, 5: SCLK period = 2^SCLK_DIV_LOG2 clk cycles; 2..8.
- RES_W, 12: result width, 1..16.
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- strt_scan  in  1  one-cycle scan request; sampled only in IDLE.
- chnnl_mask  in  NUM_CHNNL  channels to convert; captured with strt_scan.
- busy  out  1  scan in progress.
- scan_done  out  1  one-cycle pulse at scan end.
- rd_chnnl  in  3  read index; values >= NUM_CHNNL read as 0.
- rd_res  out  RES_W  combinational read of result[rd_chnnl].
- res_vld  out  NUM_CHNNL  per-channel result valid.
- a2d_SS_n  out  1  A2D select, active low.
- SCLK  out  1  SPI clock, idles high.
- MOSI  out  1  command out.
- MISO  in  1  data in.

## Operation
- FSM: IDLE -> (strt_scan, mask != 0) FRAME -> GAP -> FRAME ... -> IDLE.
- strt_scan with mask == 0: scan_done pulses next cycle, no SPI activity, busy stays 0.
- Channel order: ascending index over set mask bits; mask held in internal copy, input changes ignored while busy.
- Scan start clears res_vld for masked channels. Unmasked channels keep results and flags.
- Frame: 32 bits. tx = {2'b00, ch[2:0], 11'h000, 16'h0000}; MOSI = tx[31].
- SCLK = MSB of SCLK_DIV_LOG2-bit counter. Counter loads 2^(SCLK_DIV_LOG2-1) at frame start, so SCLK is high.
- Fall event: counter wraps to 0. tx shifts left except at the first fall.
- Rise event: counter reaches 2^(SCLK_DIV_LOG2-1). rx <= {rx[30:0], MISO}.
- Frame ends after the 32nd rise once counter = all-ones. result[ch] <= rx[RES_W-1:0] (second word); res_vld[ch] <= 1; go to GAP.
- GAP: SS_n high, SCLK high, for 2^(SCLK_DIV_LOG2-1) cycles. Then next FRAME, or IDLE with scan_done if no channels remain.
- strt_scan while busy: ignored. Reading a channel while it is being written returns the old value until the write cycle.

## Timing
- Reset values: busy 0, scan_done 0, res_vld 0, results 0, a2d_SS_n 1, SCLK 1, MOSI 0, FSM IDLE.
- a2d_SS_n falls the cycle after strt_scan is sampled. busy rises the same cycle.
- SS_n low per frame: exactly 32*2^D + 2^(D-1) cycles, D = SCLK_DIV_LOG2 (1040 at D=5).
- First SCLK fall: 2^(D-1) cycles after SS_n falls. MOSI stable ≥ 2^(D-1) cycles around each rise.
- res_vld[ch] and result update in the cycle SS_n rises.
- scan_done pulse coincides with busy falling, at the end of the last GAP.
- New strt_scan is accepted the cycle after scan_done.
- Reset mid-frame: SS_n and SCLK return high immediately (async). All state is cleared. No partial result is written.

## Configuration
- A2D_RES_INV_EN defined: stored result = ~rx[RES_W-1:0]. The line follower's IR sensors read high-is-dark.
- A2D_RES_INV_EN undefined: stored result = rx[RES_W-1:0] unmodified.

## Test plan
- Reset, no stimulus -> SS_n=1, SCLK=1, busy=0, res_vld=0 held for 100 cycles.
- D=5, mask=8'h01, slave returns 16'h0ABC in word 2 -> one SS_n low window of 1040 cycles. MOSI word 1 = 16'h0000. rd_chnnl=0 gives 12'h543 with INV_EN, 12'hABC without. res_vld=8'h01.
- mask=8'hA4, slave echoes channel code -> three frames in order 2, 5, 7. MOSI bits[13:11] = 2, 5, 7. Each GAP ≥ 16 cycles. scan_done pulses once. res_vld=8'hA4.
- mask=0 -> scan_done one cycle after strt_scan, SS_n never low.
- strt_scan pulsed mid-scan, mask input toggled -> ignored, frame count unchanged.
- rst_n low at bit 17 of a frame -> SS_n/SCLK high asynchronously, res_vld=0. Next scan completes normally.
